// File: rtl/fetch_predict_pkg.sv
// Shared types for the fetch stage: BTB entry, direction counter, IF/ID bundle.
// Struct fields use fixed maximum widths so one package serves every
// parameterisation. Modules use only the low PC_W / INSTR_W bits and keep
// PC_W <= PC_MAX_W and INSTR_W <= INSTR_MAX_W.
package fetch_predict_pkg;

  localparam int PC_MAX_W    = 32;
  localparam int INSTR_MAX_W = 32;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  typedef struct packed {
    logic                valid;
    logic [PC_MAX_W-1:0] tag;
    logic [PC_MAX_W-1:0] target;
    ctr_e                ctr;
  } btb_entry_t;

  typedef struct packed {
    logic                   valid;
    logic [PC_MAX_W-1:0]    pc;
    logic [INSTR_MAX_W-1:0] instr;
    logic                   pred_taken;
    logic [PC_MAX_W-1:0]    pred_pc;
  } ifid_t;

  // Saturating 2-bit counter step toward the resolved direction.
  function automatic ctr_e ctr_step(input ctr_e c, input logic taken);
    ctr_e r;
    r = c;
    case (c)
      SNT: r = taken ? WNT : SNT;
      WNT: r = taken ? WT  : SNT;
      WT:  r = taken ? ST  : WNT;
      ST:  r = taken ? ST  : WT;
      default: r = WNT;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fetch_predict_btb_table.sv
// Direct-mapped BTB: combinational lookup port, synchronous training port.
// A lookup to the index being trained sees the old entry (no bypass).
module btb_table
  import fetch_predict_pkg::*;
#(
  parameter int PC_W        = 16,
  parameter int INSTR_BYTES = 2,
  parameter int ENTRIES     = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [PC_W-1:0] lk_pc,
  output logic            lk_taken,
  output logic [PC_W-1:0] lk_target,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target
);

  localparam int OFF_W = $clog2(INSTR_BYTES);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - OFF_W;
  localparam btb_entry_t RST_ENTRY = '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};

  btb_entry_t mem [ENTRIES];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  btb_entry_t       lk_e, up_e, up_nxt;
  logic             lk_hit, up_hit, up_we;

  assign lk_idx = lk_pc[IDX_W+OFF_W-1:OFF_W];
  assign lk_tag = lk_pc[PC_W-1:IDX_W+OFF_W];
  assign up_idx = upd_pc[IDX_W+OFF_W-1:OFF_W];
  assign up_tag = upd_pc[PC_W-1:IDX_W+OFF_W];
  assign lk_e   = mem[lk_idx];
  assign up_e   = mem[up_idx];

  assign lk_hit    = lk_e.valid && (lk_e.tag[TAG_W-1:0] == lk_tag);
  assign lk_taken  = lk_hit && ((lk_e.ctr == WT) || (lk_e.ctr == ST));
  assign lk_target = lk_e.target[PC_W-1:0];
  assign up_hit    = up_e.valid && (up_e.tag[TAG_W-1:0] == up_tag);

  // Offset bits and the wide upper struct bits carry no information here.
  logic unused_bits;
  assign unused_bits = ^{lk_e, up_e, lk_pc, upd_pc};

  // Training: adjust counter on hit, allocate on a taken miss.
  always_comb begin
    up_we  = 1'b0;
    up_nxt = up_e;
    if (upd_valid) begin
      if (up_hit) begin
        up_we      = 1'b1;
        up_nxt.ctr = ctr_step(up_e.ctr, upd_taken);
        if (upd_taken) up_nxt.target = PC_MAX_W'(upd_target);
      end else if (upd_taken) begin
        up_we         = 1'b1;
        up_nxt.valid  = 1'b1;
        up_nxt.tag    = PC_MAX_W'(up_tag);
        up_nxt.target = PC_MAX_W'(upd_target);
        up_nxt.ctr    = WT;
      end
    end
  end

  // Storage; reset invalidates every entry and drops any same-cycle update.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) mem[i] <= RST_ENTRY;
    end else if (up_we) begin
      mem[up_idx] <= up_nxt;
    end
  end

endmodule

// File: rtl/fetch_predict.sv
// Fetch stage: PC register, next-PC select (redirect > stall > BTB > +N)
// and the IF/ID register with prediction metadata.
module fetch_predict
  import fetch_predict_pkg::*;
#(
  parameter int              PC_W        = 16,
  parameter int              INSTR_W     = 16,
  parameter int              INSTR_BYTES = 2,
  parameter int              BTB_ENTRIES = 16,
  parameter logic [PC_W-1:0] RESET_PC    = '0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_stall,
  input  logic               i_redirect,
  input  logic [PC_W-1:0]    i_redirect_pc,
  input  logic               i_upd_valid,
  input  logic [PC_W-1:0]    i_upd_pc,
  input  logic               i_upd_taken,
  input  logic [PC_W-1:0]    i_upd_target,
  output logic [PC_W-1:0]    o_imem_addr,
  input  logic [INSTR_W-1:0] i_imem_rddata,
  output logic               o_ifid_valid,
  output logic [PC_W-1:0]    o_ifid_pc,
  output logic [INSTR_W-1:0] o_ifid_instr,
  output logic               o_ifid_pred_taken,
  output logic [PC_W-1:0]    o_ifid_pred_pc
);

  logic [PC_W-1:0] pc_q, pc_d, seq_pc, fetch_next, lk_target;
  logic            lk_taken;
  ifid_t           ifid_q;

  btb_table #(
    .PC_W       (PC_W),
    .INSTR_BYTES(INSTR_BYTES),
    .ENTRIES    (BTB_ENTRIES)
  ) u_btb (
    .clk       (clk),
    .reset_n   (reset_n),
    .lk_pc     (pc_q),
    .lk_taken  (lk_taken),
    .lk_target (lk_target),
    .upd_valid (i_upd_valid),
    .upd_pc    (i_upd_pc),
    .upd_taken (i_upd_taken),
    .upd_target(i_upd_target)
  );

  assign seq_pc     = pc_q + PC_W'(INSTR_BYTES);
  assign fetch_next = lk_taken ? lk_target : seq_pc;

  // Next PC: redirect wins over stall, stall over the predicted path.
  always_comb begin
    pc_d = fetch_next;
    if (i_redirect)   pc_d = i_redirect_pc;
    else if (i_stall) pc_d = pc_q;
  end

  // PC register.
  always_ff @(posedge clk) begin
    if (!reset_n) pc_q <= RESET_PC;
    else          pc_q <= pc_d;
  end

  // IF/ID: redirect inserts a bubble, stall holds, otherwise capture fetch.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ifid_q <= '0;
    end else if (i_redirect) begin
      ifid_q.valid <= 1'b0;
    end else if (!i_stall) begin
      ifid_q.valid      <= 1'b1;
      ifid_q.pc         <= PC_MAX_W'(pc_q);
      ifid_q.instr      <= INSTR_MAX_W'(i_imem_rddata);
      ifid_q.pred_taken <= lk_taken;
      ifid_q.pred_pc    <= PC_MAX_W'(fetch_next);
    end
  end

  logic unused_ifid;
  assign unused_ifid = ^ifid_q;

  assign o_imem_addr       = pc_q;
  assign o_ifid_valid      = ifid_q.valid;
  assign o_ifid_pc         = ifid_q.pc[PC_W-1:0];
  assign o_ifid_instr      = ifid_q.instr[INSTR_W-1:0];
  assign o_ifid_pred_taken = ifid_q.pred_taken;
  assign o_ifid_pred_pc    = ifid_q.pred_pc[PC_W-1:0];

endmodule

// File: tb/tb_fetch_predict.sv
// Directed bench for fetch_predict: sequential fetch, stall, redirect,
// BTB training/hysteresis, aliasing, mid-run reset and PC wrap.
module tb_fetch_predict;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_stall, i_redirect, i_upd_valid, i_upd_taken;
  logic [15:0] i_redirect_pc, i_upd_pc, i_upd_target;
  logic [15:0] o_imem_addr, i_imem_rddata;
  logic        o_ifid_valid, o_ifid_pred_taken;
  logic [15:0] o_ifid_pc, o_ifid_instr, o_ifid_pred_pc;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Instruction memory: word is a fixed scramble of its address.
  assign i_imem_rddata = o_imem_addr ^ 16'hA5A5;

  fetch_predict dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .i_stall          (i_stall),
    .i_redirect       (i_redirect),
    .i_redirect_pc    (i_redirect_pc),
    .i_upd_valid      (i_upd_valid),
    .i_upd_pc         (i_upd_pc),
    .i_upd_taken      (i_upd_taken),
    .i_upd_target     (i_upd_target),
    .o_imem_addr      (o_imem_addr),
    .i_imem_rddata    (i_imem_rddata),
    .o_ifid_valid     (o_ifid_valid),
    .o_ifid_pc        (o_ifid_pc),
    .o_ifid_instr     (o_ifid_instr),
    .o_ifid_pred_taken(o_ifid_pred_taken),
    .o_ifid_pred_pc   (o_ifid_pred_pc)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redir(input logic [15:0] pc);
    i_redirect    = 1'b1;
    i_redirect_pc = pc;
    step();
    i_redirect    = 1'b0;
  endtask

  task automatic upd(input logic [15:0] pc, input logic tk, input logic [15:0] tgt);
    i_upd_valid  = 1'b1;
    i_upd_pc     = pc;
    i_upd_taken  = tk;
    i_upd_target = tgt;
    step();
    i_upd_valid  = 1'b0;
  endtask

  task automatic expect_fetch(input string tag, input logic [15:0] pc,
                              input logic tk, input logic [15:0] npc);
    chk({tag, ".valid"}, 32'(o_ifid_valid), 32'd1);
    chk({tag, ".pc"},    32'(o_ifid_pc), 32'(pc));
    chk({tag, ".instr"}, 32'(o_ifid_instr), 32'(pc ^ 16'hA5A5));
    chk({tag, ".ptk"},   32'(o_ifid_pred_taken), 32'(tk));
    chk({tag, ".ppc"},   32'(o_ifid_pred_pc), 32'(npc));
  endtask

  // Redirect to pc, then let it be fetched into IF/ID.
  task automatic probe(input logic [15:0] pc);
    redir(pc);
    step();
  endtask

  initial begin
    reset_n = 1'b0; i_stall = 1'b0; i_redirect = 1'b0; i_redirect_pc = '0;
    i_upd_valid = 1'b0; i_upd_pc = '0; i_upd_taken = 1'b0; i_upd_target = '0;
    step(); step();
    chk("rst.valid", 32'(o_ifid_valid), 32'd0);
    chk("rst.pc",    32'(o_ifid_pc), 32'd0);
    chk("rst.addr",  32'(o_imem_addr), 32'd0);
    chk("rst.ptk",   32'(o_ifid_pred_taken), 32'd0);

    // Sequential fetch
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      expect_fetch($sformatf("seq%0d", i), 16'(2*i), 1'b0, 16'(2*i + 2));
    end
    chk("seq.addr", 32'(o_imem_addr), 32'h8);

    // Stall at PC=8
    i_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stall%0d.addr", i), 32'(o_imem_addr), 32'h8);
      chk($sformatf("stall%0d.pc", i),   32'(o_ifid_pc), 32'h6);
    end
    i_stall = 1'b0;
    step();
    expect_fetch("unstall", 16'h8, 1'b0, 16'hA);

    // Redirect during stall
    i_stall = 1'b1;
    redir(16'h40);
    i_stall = 1'b0;
    chk("redir.valid", 32'(o_ifid_valid), 32'd0);
    chk("redir.addr",  32'(o_imem_addr), 32'h40);
    step();
    expect_fetch("redir.tgt", 16'h40, 1'b0, 16'h42);

    // Train 0x10 -> 0x80 (alloc at WT), then walk into it
    upd(16'h10, 1'b1, 16'h80);
    probe(16'h0C);
    expect_fetch("trn.0c", 16'h0C, 1'b0, 16'h0E);
    step();
    step();
    expect_fetch("trn.10", 16'h10, 1'b1, 16'h80);
    chk("trn.addr", 32'(o_imem_addr), 32'h80);
    step();
    expect_fetch("trn.80", 16'h80, 1'b0, 16'h82);

    // Hysteresis: WT -nt-> WNT
    upd(16'h10, 1'b0, 16'h0);
    probe(16'h10);
    expect_fetch("hy.wnt", 16'h10, 1'b0, 16'h12);
    // WNT -t-> WT -t-> ST
    upd(16'h10, 1'b1, 16'h80);
    upd(16'h10, 1'b1, 16'h80);
    probe(16'h10);
    expect_fetch("hy.st", 16'h10, 1'b1, 16'h80);
    // ST -nt-> WT still taken
    upd(16'h10, 1'b0, 16'h0);
    probe(16'h10);
    expect_fetch("hy.wt", 16'h10, 1'b1, 16'h80);

    // Same-cycle lookup and update: lookup sees pre-update WT
    redir(16'h10);
    upd(16'h10, 1'b0, 16'h0);
    expect_fetch("byp.pre", 16'h10, 1'b1, 16'h80);
    probe(16'h10);
    expect_fetch("byp.post", 16'h10, 1'b0, 16'h12);

    // Alias: 0x30 shares index 8 with 0x10 and evicts it
    upd(16'h30, 1'b1, 16'h90);
    probe(16'h10);
    expect_fetch("al.10", 16'h10, 1'b0, 16'h12);
    probe(16'h30);
    expect_fetch("al.30", 16'h30, 1'b1, 16'h90);

    // Mid-run reset with a concurrent update that must be dropped
    reset_n = 1'b0;
    i_upd_valid = 1'b1; i_upd_pc = 16'h50; i_upd_taken = 1'b1; i_upd_target = 16'hA0;
    step();
    reset_n = 1'b1; i_upd_valid = 1'b0;
    chk("mrst.valid", 32'(o_ifid_valid), 32'd0);
    chk("mrst.addr",  32'(o_imem_addr), 32'd0);
    chk("mrst.pc",    32'(o_ifid_pc), 32'd0);
    step();
    expect_fetch("mrst.first", 16'h0, 1'b0, 16'h2);
    probe(16'h30);
    expect_fetch("mrst.30", 16'h30, 1'b0, 16'h32);
    probe(16'h50);
    expect_fetch("mrst.50", 16'h50, 1'b0, 16'h52);

    // Sequential increment wraps
    probe(16'hFFFE);
    expect_fetch("wrap", 16'hFFFE, 1'b0, 16'h0000);
    chk("wrap.addr", 32'(o_imem_addr), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
